// File: rtl/uart_recv_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_recv_if : serial line in, received byte/strobes out of uart_recv    |
// | rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
interface uart_recv_if;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    // master: line driver and byte consumer; slave: the receiver itself
    modport master (output din, input data, valid, frame_err, busy);
    modport slave  (input din, output data, valid, frame_err, busy);
endinterface
`default_nettype wire

// File: rtl/uart_recv.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_recv : 8N1 UART receiver, single mid-bit sample, framing-error flag |
// | Option    : define UART_RECV_SYNC_EN for a 2-flop din synchronizer       |
// | rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
module uart_recv #(
    parameter int CLKS_PER_BIT = 1
) (
    input wire        clk,
    input wire        rst,
    uart_recv_if.slave bus
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic        rx;
    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  idx;
    logic [7:0]  shreg;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        err_q;
    logic        busy_q;
    logic        sample;
    logic [15:0] cnt_next;

`ifdef UART_RECV_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], bus.din};
        end
    end

    assign rx = sync[1];
`else
    assign rx = bus.din;
`endif

    // cnt holds (cycles since start detection) mod CLKS_PER_BIT
    assign sample   = (cnt == HALF);
    assign cnt_next = (cnt == LAST) ? 16'd0 : cnt + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 16'd0;
            idx     <= 4'd0;
            shreg   <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt    <= 16'd0;
                    idx    <= 4'd0;
                    busy_q <= 1'b0;
                    if (!rx) begin
                        cnt    <= (LAST == 16'd0) ? 16'd0 : 16'd1;
                        busy_q <= 1'b1;
                        // with a zero sample offset the detection edge is the start-bit check
                        if (HALF == 16'd0) begin
                            state <= S_DATA;
                            idx   <= 4'd1;
                        end else begin
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    cnt <= cnt_next;
                    if (sample) begin
                        if (rx) begin
                            state  <= S_IDLE;
                            cnt    <= 16'd0;
                            busy_q <= 1'b0;
                        end else begin
                            state <= S_DATA;
                            idx   <= 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    cnt <= cnt_next;
                    if (sample) begin
                        shreg <= {rx, shreg[7:1]};
                        idx   <= idx + 4'd1;
                        if (idx == 4'd8) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    cnt <= cnt_next;
                    if (sample) begin
                        cnt <= 16'd0;
                        idx <= 4'd0;
                        if (rx) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            err_q <= 1'b1;
                            state <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // hold off until the line is released so a long low is not re-read as starts
                    if (rx) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    cnt    <= 16'd0;
                    idx    <= 4'd0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_uart_recv : scoreboard bench for uart_recv at N=1 and N=16            |
// | rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
module tb_uart_recv;

`ifdef UART_RECV_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    typedef struct {
        bit         err;
        logic [7:0] data;
        longint     at;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    longint edges = 0;
    int     total = 0;
    int     bad = 0;
    exp_t   q1[$];
    exp_t   q16[$];
    logic [7:0] last1 = 8'h00;
    logic [7:0] last16 = 8'h00;

    uart_recv_if u_if1 ();
    uart_recv_if u_if16 ();

    uart_recv #(.CLKS_PER_BIT(1))  u_dut1  (.clk(clk), .rst(rst), .bus(u_if1));
    uart_recv #(.CLKS_PER_BIT(16)) u_dut16 (.clk(clk), .rst(rst), .bus(u_if16));

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic setdin(input int sel, input logic b);
        if (sel == 0) u_if1.din = b;
        else          u_if16.din = b;
    endtask

    function automatic logic getbusy(input int sel);
        return (sel == 0) ? u_if1.busy : u_if16.busy;
    endfunction

    task automatic idle(input int sel, input int n);
        repeat (n) begin
            @(negedge clk);
            setdin(sel, 1'b1);
        end
    endtask

    task automatic push(input int sel, input exp_t x);
        if (sel == 0) q1.push_back(x);
        else          q16.push_back(x);
    endtask

    // Drives start, 8 data bits LSB first and stop, each held N cycles; the
    // expected pulse is queued the moment the start bit goes out.
    task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit);
        int         n;
        int         h;
        longint     t0;
        logic [9:0] bits;
        exp_t       x;
        n    = (sel == 0) ? 1 : 16;
        h    = (n - 1) / 2;
        bits = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) begin
                    t0   = edges + 1;
                    x.at = t0 + 9 * n + h + SYNC;
                    x.err = !stop_bit;
                    if (sel == 0) begin
                        x.data = stop_bit ? b : last1;
                        if (stop_bit) last1 = b;
                    end else begin
                        x.data = stop_bit ? b : last16;
                        if (stop_bit) last16 = b;
                    end
                    push(sel, x);
                end
                if (c == 0 && k > 0 && (k * n - 1) >= SYNC)
                    chk($sformatf("busy_in_frame_n%0d_bit%0d", n, k), getbusy(sel), 1);
                setdin(sel, bits[k]);
            end
        end
    endtask

    task automatic mon_one(input int sel, input logic v, input logic e, input logic [7:0] d);
        exp_t x;
        bit   have;
        have = (sel == 0) ? (q1.size() != 0) : (q16.size() != 0);
        if (have) x = (sel == 0) ? q1[0] : q16[0];
        if (v || e) begin
            if (!have) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse dut%0d: valid=%0b frame_err=%0b data=%0h at edge %0d, none expected",
                         sel, v, e, d, edges);
            end else begin
                if (sel == 0) void'(q1.pop_front());
                else          void'(q16.pop_front());
                chk($sformatf("pulse_kind_dut%0d {valid,frame_err}", sel), {v, e}, x.err ? 2'b01 : 2'b10);
                chk($sformatf("pulse_data_dut%0d", sel), d, x.data);
                chk($sformatf("pulse_edge_dut%0d", sel), edges, x.at);
            end
        end else if (have && edges > x.at) begin
            if (sel == 0) void'(q1.pop_front());
            else          void'(q16.pop_front());
            total++;
            bad++;
            $display("FAIL missed_pulse dut%0d: no pulse by edge %0d, expected at edge %0d", sel, edges, x.at);
        end
    endtask

    task automatic stimulus();
        longint t0;
        idle(0, 3);
        send_frame(0, 8'hA5, 1'b1);
        idle(0, 3);
        chk("data_after_a5", u_if1.data, 8'hA5);

        // stop bit low, line held low five cycles in total
        send_frame(0, 8'hC3, 1'b0);
        repeat (4) begin
            @(negedge clk);
            setdin(0, 1'b0);
        end
        @(negedge clk);
        chk("break_busy_while_low", u_if1.busy, 1);
        setdin(0, 1'b1);
        repeat (3) @(negedge clk);
        chk("break_released", u_if1.busy, 0);
        idle(0, 5);
        chk("no_restart_after_break", u_if1.busy, 0);
        chk("data_kept_after_err", u_if1.data, 8'hA5);

        send_frame(0, 8'h01, 1'b1);
        idle(0, 1);
        send_frame(0, 8'hFE, 1'b1);
        idle(0, 5);
        chk("data_after_fe", u_if1.data, 8'hFE);

        // N=16 glitch: four low cycles, then high before the mid-start check
        @(negedge clk);
        t0 = edges + 1;
        setdin(1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            setdin(1, 1'b0);
        end
        @(negedge clk);
        chk("glitch_busy_start", u_if16.busy, 1);
        setdin(1, 1'b1);
        idle(1, 12);
        chk("glitch_back_to_idle", u_if16.busy, 0);
        chk("glitch_edge_sanity", (edges > t0 + 9 + SYNC) ? 1 : 0, 1);

        send_frame(1, 8'h3C, 1'b1);
        idle(1, 20);
        chk("data_after_3c", u_if16.data, 8'h3C);

        // reset in the middle of the data bits of an N=1 frame
        @(negedge clk);
        setdin(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            setdin(0, i[0] ? 1'b0 : 1'b1);
        end
        @(negedge clk);
        chk("busy_before_reset", u_if1.busy, 1);
        rst = 1'b0;
        #1;
        chk("async_reset_data", u_if1.data, 8'h00);
        chk("async_reset_busy", u_if1.busy, 0);
        chk("async_reset_valid", u_if1.valid, 0);
        chk("async_reset_frame_err", u_if1.frame_err, 0);
        setdin(0, 1'b1);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        last1 = 8'h00;
        idle(0, 3);
        send_frame(0, 8'h55, 1'b1);
        idle(0, 10);
        chk("data_after_55", u_if1.data, 8'h55);
    endtask

    initial begin
        rst        = 1'b0;
        u_if1.din  = 1'b1;
        u_if16.din = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", u_if1.data, 8'h00);
        chk("reset_valid", u_if1.valid, 0);
        chk("reset_frame_err", u_if1.frame_err, 0);
        chk("reset_busy", u_if1.busy, 0);
        chk("reset_busy_n16", u_if16.busy, 0);
        rst = 1'b1;
        fork
            forever begin
                @(negedge clk);
                mon_one(0, u_if1.valid, u_if1.frame_err, u_if1.data);
                mon_one(1, u_if16.valid, u_if16.frame_err, u_if16.data);
            end
            stimulus();
        join_any
        disable fork;
        chk("pending_n1", q1.size(), 0);
        chk("pending_n16", q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
